// File: rtl/scalar_pkg.sv
// Shared types and encodings for the scalar-unit arbiter.
package scalar_pkg;

  // Default fixed-point format and vector length.
  localparam int DEF_IL   = 4;
  localparam int DEF_FL   = 16;
  localparam int DEF_SIZE = 16;

  typedef logic signed [DEF_IL+DEF_FL-1:0] elem_t;
  typedef elem_t [DEF_SIZE-1:0]            vec_t;

  // Scalar unit status codes; anything else means the unit is busy.
  localparam logic [1:0] SC_IDLE = 2'b00;
  localparam logic [1:0] SC_DONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESP    = 3'd4
  } arb_state_e;

endpackage

// File: rtl/scalar_arbiter_if.sv
// Requester and scalar-unit signal bundle for the arbiter.
//
// Handshakes: a requester holds req and its operands stable until it sees
// its one-cycle gnt pulse. A result transfers on the cycle where
// rsp_valid[i] and rsp_ready[i] are both high; rsp_valid, rsp_data and
// rsp_err stay stable until then. Toward the scalar unit, sc_input_ready
// pulses once when operands are presented and sc_output_taken pulses once
// after the result (or a timeout) has been captured.
interface scalar_arbiter_if #(
  parameter int NREQ = 4,
  parameter int EW   = 20,
  parameter int SIZE = 16
);
  logic [NREQ-1:0]                      req;
  logic [NREQ-1:0][1:0]                 req_mode;
  logic [NREQ-1:0][SIZE-1:0][EW-1:0]    req_in1;
  logic [NREQ-1:0][SIZE-1:0][EW-1:0]    req_in2;
  logic [NREQ-1:0]                      gnt;
  logic [NREQ-1:0]                      rsp_valid;
  logic [NREQ-1:0]                      rsp_ready;
  logic                                 rsp_err;
  logic [SIZE-1:0][EW-1:0]              rsp_data;
  logic                                 busy;
  logic [1:0]                           sc_mode;
  logic [SIZE-1:0][EW-1:0]              sc_in1;
  logic [SIZE-1:0][EW-1:0]              sc_in2;
  logic                                 sc_input_ready;
  logic                                 sc_output_taken;
  logic [1:0]                           sc_state;
  logic [SIZE-1:0][EW-1:0]              sc_out;
  logic [2:0]                           dbg_state;

  // Arbiter side.
  modport master (
    input  req, req_mode, req_in1, req_in2, rsp_ready, sc_state, sc_out,
    output gnt, rsp_valid, rsp_err, rsp_data, busy,
           sc_mode, sc_in1, sc_in2, sc_input_ready, sc_output_taken, dbg_state
  );

  // Requesters and scalar unit side.
  modport slave (
    output req, req_mode, req_in1, req_in2, rsp_ready, sc_state, sc_out,
    input  gnt, rsp_valid, rsp_err, rsp_data, busy,
           sc_mode, sc_in1, sc_in2, sc_input_ready, sc_output_taken, dbg_state
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o,
  output logic            any_o
);
  int             sum;
  logic [IDW-1:0] idx;

  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        id_o       = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/scalar_arbiter.sv
// Round-robin arbiter/sequencer sharing one scalar vector unit.
// All outputs come from registers or are decoded from the state register,
// so nothing combinational leaks from req/rsp_ready to the outputs.
module scalar_arbiter
  import scalar_pkg::*;
#(
  parameter int IL      = DEF_IL,
  parameter int FL      = DEF_FL,
  parameter int size    = DEF_SIZE,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  scalar_arbiter_if.master bus
);
  localparam int EW  = IL + FL;
  localparam int IDW = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef logic signed [EW-1:0] el_t;

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]      mode_q, mode_d;
  el_t [size-1:0]  in1_q, in1_d;
  el_t [size-1:0]  in2_q, in2_d;
  el_t [size-1:0]  rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [WDW-1:0]  wd_q, wd_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .id_o  (pick_id),
    .any_o (pick_any)
  );

  // State, watchdog and data registers; reset aborts any operation silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      mode_q     <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      mode_q     <= mode_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wd_q       <= wd_d;
    end
  end

  // Next-state logic: grant only from IDLE, pointer moves only on RESP exit,
  // so the two never coincide.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    mode_d     = mode_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wd_d       = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && bus.sc_state == SC_IDLE) begin
          id_d    = pick_id;
          owner_d = pick_gnt;
          mode_d  = bus.req_mode[pick_id];
          in1_d   = bus.req_in1[pick_id];
          in2_d   = bus.req_in2[pick_id];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sc_state == SC_DONE) begin
          rsp_data_d = bus.sc_out;
          rsp_err_d  = 1'b0;
          state_d    = ST_RELEASE;
        end else if (wd_q == WDW'(TIMEOUT)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RELEASE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready[id_q]) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register and latched data.
  always_comb begin
    bus.gnt             = (state_q == ST_ISSUE) ? owner_q : '0;
    bus.rsp_valid       = (state_q == ST_RESP)  ? owner_q : '0;
    bus.rsp_err         = (state_q == ST_RESP) && rsp_err_q;
    bus.rsp_data        = rsp_data_q;
    bus.busy            = (state_q != ST_IDLE);
    bus.sc_mode         = mode_q;
    bus.sc_in1          = in1_q;
    bus.sc_in2          = in2_q;
    bus.sc_input_ready  = (state_q == ST_ISSUE);
    bus.sc_output_taken = (state_q == ST_RELEASE);
    bus.dbg_state       = state_q;
  end
endmodule

// File: tb/tb_scalar_arbiter.sv
// Directed bench for scalar_arbiter with a simple adding scalar-unit stub.
module tb_scalar_arbiter;
  import scalar_pkg::*;

  localparam int NREQ    = 4;
  localparam int EW      = 20;
  localparam int SIZE    = 16;
  localparam int TIMEOUT = 255;
  localparam int VW      = SIZE * EW;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [1:0]              stub_state;
  logic                    stub_cnt;
  logic [SIZE-1:0][EW-1:0] stub_out;
  logic                    hang;
  logic                    force_busy;

  scalar_arbiter_if #(.NREQ(NREQ), .EW(EW), .SIZE(SIZE)) bus ();

  scalar_arbiter #(.IL(4), .FL(16), .size(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar stub: latches in1+in2, DONE three cycles after input_ready.
  assign bus.sc_state = force_busy ? 2'b01 : stub_state;
  assign bus.sc_out   = stub_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_state <= 2'b00;
      stub_cnt   <= 1'b0;
      stub_out   <= '0;
    end else if (bus.sc_input_ready) begin
      for (int j = 0; j < SIZE; j++) stub_out[j] <= bus.sc_in1[j] + bus.sc_in2[j];
      stub_state <= 2'b01;
      stub_cnt   <= 1'b1;
    end else if (bus.sc_output_taken) begin
      stub_state <= 2'b00;
    end else if (stub_state == 2'b01 && !hang) begin
      if (stub_cnt == 1'b0) stub_state <= 2'b11;
      else                  stub_cnt   <= 1'b0;
    end
  end

  // scoreboard helpers
  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec_lin(input int a, input int b);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < SIZE; j++) v[j*EW +: EW] = EW'(a * j + b);
    return v;
  endfunction

  // Waits on negedges for a condition; sel 0=gnt 1=rsp_valid 2=output_taken 3=idle.
  task automatic wait_cond(input string tag, input int sel, input int bound, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < bound) begin
      @(negedge clk);
      cyc++;
      case (sel)
        0: hit = (bus.gnt != '0);
        1: hit = (bus.rsp_valid != '0);
        2: hit = bus.sc_output_taken;
        default: hit = !bus.busy;
      endcase
    end
    n_cmp++;
    assert (hit) else begin
      n_bad++;
      $error("FAIL %s_timeout observed=no_event expected=event_within_%0d", tag, bound);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // stimulus
  initial begin
    int cyc;
    logic [VW-1:0] held;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    hang = 1'b0;
    force_busy = 1'b0;
    bus.req = '0;
    bus.req_mode = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < SIZE; j++) begin
        bus.req_in1[i][j] = EW'(i);
        bus.req_in2[i][j] = EW'(j);
      end
    repeat (2) @(negedge clk);

    // reset state
    check("rst_gnt", VW'(bus.gnt), '0);
    check("rst_rsp_valid", VW'(bus.rsp_valid), '0);
    check("rst_rsp_err", VW'(bus.rsp_err), '0);
    check("rst_busy", VW'(bus.busy), '0);
    check("rst_in_rdy", VW'(bus.sc_input_ready), '0);
    check("rst_out_taken", VW'(bus.sc_output_taken), '0);
    check("rst_rsp_data", bus.rsp_data, '0);
    check("rst_sc_in1", bus.sc_in1, '0);
    check("rst_state", VW'(bus.dbg_state), VW'(ST_IDLE));
    rst_n = 1'b1;

    // single request on requester 2: in1=2j+1, in2=j
    @(negedge clk);
    for (int j = 0; j < SIZE; j++) begin
      bus.req_in1[2][j] = EW'(2 * j + 1);
      bus.req_in2[2][j] = EW'(j);
    end
    bus.req = 4'b0100;
    wait_cond("t1_gnt", 0, 20, cyc);
    check("t1_gnt_latency", VW'(cyc), VW'(1));
    check("t1_gnt", VW'(bus.gnt), VW'(4'b0100));
    check("t1_in_rdy", VW'(bus.sc_input_ready), VW'(1'b1));
    check("t1_sc_in1", bus.sc_in1, vec_lin(2, 1));
    bus.req = '0;
    wait_cond("t1_taken", 2, 20, cyc);
    check("t1_taken_cycle", VW'(cyc), VW'(4));
    check("t1_valid_before", VW'(bus.rsp_valid), '0);
    @(negedge clk);
    check("t1_taken_pulse", VW'(bus.sc_output_taken), '0);
    check("t1_valid", VW'(bus.rsp_valid), VW'(4'b0100));
    check("t1_data", bus.rsp_data, vec_lin(3, 1));
    check("t1_err", VW'(bus.rsp_err), '0);
    bus.rsp_ready = 4'b0100;
    @(negedge clk);
    check("t1_done_busy", VW'(bus.busy), '0);
    check("t1_done_valid", VW'(bus.rsp_valid), '0);

    // all requesters busy, round-robin 0,1,2,3,0 from a fresh pointer
    for (int j = 0; j < SIZE; j++) begin
      bus.req_in1[2][j] = EW'(2);
      bus.req_in2[2][j] = EW'(j);
    end
    reset_pulse();
    bus.rsp_ready = 4'b1111;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_cond("rr_gnt", 0, 30, cyc);
      check($sformatf("rr_gnt%0d", k), VW'(bus.gnt), VW'(4'b0001 << (k % 4)));
      if (k == 4) bus.req = '0;
      wait_cond("rr_rsp", 1, 30, cyc);
      check($sformatf("rr_rsp_id%0d", k), VW'(bus.rsp_valid), VW'(4'b0001 << (k % 4)));
      check($sformatf("rr_data%0d", k), bus.rsp_data, vec_lin(1, k % 4));
    end
    wait_cond("rr_idle", 3, 10, cyc);

    // backpressure on requester 1 (pointer now at 1)
    bus.rsp_ready = 4'b1101;
    bus.req = 4'b1111;
    wait_cond("bp_gnt", 0, 30, cyc);
    check("bp_gnt", VW'(bus.gnt), VW'(4'b0010));
    wait_cond("bp_rsp", 1, 30, cyc);
    held = bus.rsp_data;
    check("bp_data", held, vec_lin(1, 1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", VW'(bus.rsp_valid), VW'(4'b0010));
      check("bp_hold_data", bus.rsp_data, vec_lin(1, 1));
      check("bp_no_gnt", VW'(bus.gnt), '0);
    end
    bus.rsp_ready = 4'b1111;
    wait_cond("bp_next_gnt", 0, 30, cyc);
    check("bp_next_gnt", VW'(bus.gnt), VW'(4'b0100));
    bus.req = '0;
    wait_cond("bp_idle", 3, 30, cyc);

    // timeout on requester 3 (pointer now at 3)
    hang = 1'b1;
    bus.req = 4'b1000;
    wait_cond("to_gnt", 0, 30, cyc);
    check("to_gnt", VW'(bus.gnt), VW'(4'b1000));
    bus.req = '0;
    wait_cond("to_taken", 2, TIMEOUT + 20, cyc);
    check("to_taken_cycle", VW'(cyc), VW'(TIMEOUT + 2));
    @(negedge clk);
    check("to_valid", VW'(bus.rsp_valid), VW'(4'b1000));
    check("to_err", VW'(bus.rsp_err), VW'(1'b1));
    check("to_data", bus.rsp_data, '0);
    hang = 1'b0;
    bus.req = 4'b0001;
    wait_cond("to_next_gnt", 0, 30, cyc);
    check("to_next_gnt", VW'(bus.gnt), VW'(4'b0001));
    bus.req = '0;
    wait_cond("to_next_rsp", 1, 30, cyc);
    check("to_next_err", VW'(bus.rsp_err), '0);
    check("to_next_data", bus.rsp_data, vec_lin(1, 0));
    wait_cond("to_idle", 3, 10, cyc);

    // asynchronous reset while waiting on the scalar unit
    hang = 1'b1;
    bus.req = 4'b0010;
    wait_cond("ar_gnt", 0, 30, cyc);
    check("ar_gnt", VW'(bus.gnt), VW'(4'b0010));
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("ar_busy_before", VW'(bus.busy), VW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", VW'(bus.busy), '0);
    check("ar_gnt_low", VW'(bus.gnt), '0);
    check("ar_valid", VW'(bus.rsp_valid), '0);
    check("ar_in_rdy", VW'(bus.sc_input_ready), '0);
    check("ar_taken", VW'(bus.sc_output_taken), '0);
    check("ar_err", VW'(bus.rsp_err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    bus.req = 4'b1111;
    wait_cond("ar_first_gnt", 0, 30, cyc);
    check("ar_first_gnt", VW'(bus.gnt), VW'(4'b0001));
    bus.req = '0;
    wait_cond("ar_idle", 3, 30, cyc);

    // scalar unit busy: hold off until it reports IDLE
    force_busy = 1'b1;
    bus.req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("hb_no_gnt", VW'(bus.gnt), '0);
      check("hb_idle", VW'(bus.busy), '0);
    end
    force_busy = 1'b0;
    wait_cond("hb_gnt", 0, 10, cyc);
    check("hb_gnt_latency", VW'(cyc), VW'(1));
    check("hb_gnt", VW'(bus.gnt), VW'(4'b0001));
    bus.req = '0;
    wait_cond("hb_idle_end", 3, 30, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end
endmodule
